bomb_controller: RTL and testbench

BOMB_CONTROLLER -- requirements
Module: bomb_controller

---
 rtl/bomb_pkg.sv | 24 ++
 rtl/bomb_slot.sv | 89 ++++++++
 rtl/bomb_controller.sv | 163 ++++++++++++++++
 tb/tb_bomb_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bomb_pkg.sv
// Purpose: shared grid geometry, slot state encoding and grid mask type for the
//          bomb controller and its per-bomb slot.
// Contents: GRID_W, GRID_CELLS, CELL_PX, ORIGIN_PX, index widths, slot_state_t, grid_t.
package bomb_pkg;

    localparam int unsigned GRID_W     = 12;
    localparam int unsigned GRID_CELLS = 144;
    localparam int unsigned CELL_PX    = 40;
    localparam int unsigned ORIGIN_PX  = 20;

    // Row/column fit in 4 bits, a flat cell index (0..143) in 8 bits.
    localparam int unsigned RC_W  = 4;
    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FUSE  = 2'd1,
        BLAST = 2'd2
    } slot_state_t;

    // One bit per grid cell, bit index = row*GRID_W + col.
    typedef logic [GRID_CELLS-1:0] grid_t;

endpackage

// File: rtl/bomb_slot.sv
// Purpose: one live-bomb slot: IDLE -> FUSE -> BLAST -> IDLE sequencing with a
//          frame counter, the bomb cell and the blast mask latched on BLAST entry.
// Ports:
//   clk, reset                 frame clock, synchronous active-high reset
//   load, load_row/col/idx     allocate this slot to a new bomb (honoured only in IDLE)
//   explosion_map              current union of all blasts (chain trigger)
//   blast_in, tree_map         blast set for this slot's cell, current tree occupancy
//   state, row, col, idx       slot state and bomb cell
//   blast                      latched blast mask, zero outside BLAST
//   tree_clear                 trees hit, asserted for the single BLAST-entry cycle
module bomb_slot
    import bomb_pkg::*;
#(
    parameter int unsigned FUSE_FRAMES  = 120,
    parameter int unsigned BLAST_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RC_W-1:0]  load_row,
    input  logic [RC_W-1:0]  load_col,
    input  logic [IDX_W-1:0] load_idx,
    input  grid_t            explosion_map,
    input  grid_t            blast_in,
    input  grid_t            tree_map,
    output slot_state_t      state,
    output logic [RC_W-1:0]  row,
    output logic [RC_W-1:0]  col,
    output logic [IDX_W-1:0] idx,
    output grid_t            blast,
    output grid_t            tree_clear
);

    localparam int unsigned CNT_MAX = (FUSE_FRAMES > BLAST_FRAMES) ? FUSE_FRAMES : BLAST_FRAMES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt;

    // Slot FSM; a FUSE bomb caught in any live blast detonates on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            row        <= '0;
            col        <= '0;
            idx        <= '0;
            blast      <= '0;
            tree_clear <= '0;
        end else begin
            tree_clear <= '0;
            unique case (state)
                IDLE: begin
                    if (load) begin
                        state <= FUSE;
                        cnt   <= '0;
                        row   <= load_row;
                        col   <= load_col;
                        idx   <= load_idx;
                    end
                end
                FUSE: begin
                    if ((cnt == CNT_W'(FUSE_FRAMES - 1)) || explosion_map[idx]) begin
                        state      <= BLAST;
                        cnt        <= '0;
                        blast      <= blast_in;
                        tree_clear <= blast_in & tree_map;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BLAST: begin
                    if (cnt == CNT_W'(BLAST_FRAMES - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        blast <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    blast <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bomb_controller.sv
// Purpose: bomb placement and blast controller for a 12x12 grid game.
//          Converts pixel coordinates to a cell, allocates a free slot, computes
//          each slot's cross-shaped blast mask and merges slot state into maps.
// Ports:
//   Frame_Clk, Reset           frame clock, synchronous active-high reset
//   Place_Req, Place_X/Y       one-cycle placement request at a cell's pixel centre
//   Wall_Map, Tree_Map         grid occupancy (bit = row*12+col)
//   Bomb_Map                   cells holding a fusing bomb
//   Explosion_Map              union of all active blast cells
//   Tree_Clear                 one-cycle mask of trees destroyed
//   Place_Ack, Place_Nack      registered accept / reject pulses
module bomb_controller
    import bomb_pkg::*;
#(
    parameter int unsigned NUM_SLOTS    = 4,
    parameter int unsigned FUSE_FRAMES  = 120,
    parameter int unsigned BLAST_FRAMES = 30,
    parameter int unsigned BLAST_RANGE  = 2
) (
    input  logic           Frame_Clk,
    input  logic           Reset,
    input  logic           Place_Req,
    input  logic [9:0]     Place_X,
    input  logic [9:0]     Place_Y,
    input  logic [143:0]   Wall_Map,
    input  logic [143:0]   Tree_Map,
    output logic [143:0]   Bomb_Map,
    output logic [143:0]   Explosion_Map,
    output logic [143:0]   Tree_Clear,
    output logic           Place_Ack,
    output logic           Place_Nack
);

    localparam int GW = int'(GRID_W);

    slot_state_t      slot_state [NUM_SLOTS];
    logic [RC_W-1:0]  slot_row   [NUM_SLOTS];
    logic [RC_W-1:0]  slot_col   [NUM_SLOTS];
    logic [IDX_W-1:0] slot_idx   [NUM_SLOTS];
    grid_t            slot_blast [NUM_SLOTS];
    grid_t            slot_tree  [NUM_SLOTS];
    grid_t            slot_bin   [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] load;

    grid_t bomb_map, explosion_map, tree_clear;

    logic [9:0]       x_off, y_off, col_q, row_q;
    logic             in_range, blocked, any_idle, accept;
    logic [RC_W-1:0]  req_row, req_col;
    logic [IDX_W-1:0] req_idx;

    // Bomb cell plus up to BLAST_RANGE cells per arm; walls stop before, trees stop at.
    function automatic grid_t blast_mask(input logic [RC_W-1:0] r0, input logic [RC_W-1:0] c0,
                                         input grid_t walls, input grid_t trees);
        grid_t m;
        int    r, c;
        logic  go;
        m = '0;
        m[IDX_W'(int'(r0) * GW + int'(c0))] = 1'b1;
        for (int d = 0; d < 4; d++) begin
            go = 1'b1;
            r  = int'(r0);
            c  = int'(c0);
            for (int s = 1; s <= int'(BLAST_RANGE); s++) begin
                if (d == 0)      r = r - 1;
                else if (d == 1) r = r + 1;
                else if (d == 2) c = c - 1;
                else             c = c + 1;
                if (go) begin
                    if (r < 0 || r >= GW || c < 0 || c >= GW) begin
                        go = 1'b0;
                    end else if (walls[IDX_W'(r * GW + c)]) begin
                        go = 1'b0;
                    end else begin
                        m[IDX_W'(r * GW + c)] = 1'b1;
                        if (trees[IDX_W'(r * GW + c)]) go = 1'b0;
                    end
                end
            end
        end
        return m;
    endfunction

    for (genvar i = 0; i < int'(NUM_SLOTS); i++) begin : g_slot
        bomb_slot #(
            .FUSE_FRAMES  (FUSE_FRAMES),
            .BLAST_FRAMES (BLAST_FRAMES)
        ) u_slot (
            .clk           (Frame_Clk),
            .reset         (Reset),
            .load          (load[i]),
            .load_row      (req_row),
            .load_col      (req_col),
            .load_idx      (req_idx),
            .explosion_map (explosion_map),
            .blast_in      (slot_bin[i]),
            .tree_map      (Tree_Map),
            .state         (slot_state[i]),
            .row           (slot_row[i]),
            .col           (slot_col[i]),
            .idx           (slot_idx[i]),
            .blast         (slot_blast[i]),
            .tree_clear    (slot_tree[i])
        );
    end

    // Merge slot state into the grid-wide maps.
    always_comb begin
        bomb_map      = '0;
        explosion_map = '0;
        tree_clear    = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            slot_bin[i] = blast_mask(slot_row[i], slot_col[i], Wall_Map, Tree_Map);
            if (slot_state[i] == FUSE) bomb_map[slot_idx[i]] = 1'b1;
            explosion_map = explosion_map | slot_blast[i];
            tree_clear    = tree_clear | slot_tree[i];
        end
    end

    assign Bomb_Map      = bomb_map;
    assign Explosion_Map = explosion_map;
    assign Tree_Clear    = tree_clear;

    // Pixel-to-cell decode; coordinates left of/above the origin never wrap into range.
    always_comb begin
        x_off    = Place_X - 10'(ORIGIN_PX);
        y_off    = Place_Y - 10'(ORIGIN_PX);
        col_q    = x_off / 10'(CELL_PX);
        row_q    = y_off / 10'(CELL_PX);
        in_range = (Place_X >= 10'(ORIGIN_PX)) && (Place_Y >= 10'(ORIGIN_PX)) &&
                   (col_q < 10'(GRID_W)) && (row_q < 10'(GRID_W));
        req_col  = RC_W'(col_q);
        req_row  = RC_W'(row_q);
        req_idx  = IDX_W'(req_row) * IDX_W'(GRID_W) + IDX_W'(req_col);
        blocked  = Wall_Map[req_idx] | Tree_Map[req_idx] |
                   bomb_map[req_idx] | explosion_map[req_idx];
    end

    // Lowest-numbered IDLE slot takes the bomb; a slot freeing this edge is not yet IDLE.
    always_comb begin
        load     = '0;
        any_idle = 1'b0;
        accept   = Place_Req && !Reset && in_range && !blocked;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!any_idle && slot_state[i] == IDLE) begin
                any_idle = 1'b1;
                load[i]  = accept;
            end
        end
        accept = accept && any_idle;
    end

    always_ff @(posedge Frame_Clk) begin
        if (Reset) begin
            Place_Ack  <= 1'b0;
            Place_Nack <= 1'b0;
        end else begin
            Place_Ack  <= accept;
            Place_Nack <= Place_Req && !accept;
        end
    end

endmodule

// File: tb/tb_bomb_controller.sv
// Purpose: self-checking bench for bomb_controller. Placement outcomes go through an
//          ack/nack scoreboard; map contents are checked inline per scenario.
module tb_bomb_controller;

    logic         Frame_Clk = 1'b0;
    logic         Reset;
    logic         Place_Req;
    logic [9:0]   Place_X, Place_Y;
    logic [143:0] Wall_Map, Tree_Map;
    logic [143:0] Bomb_Map, Explosion_Map, Tree_Clear;
    logic         Place_Ack, Place_Nack;

    int checks = 0;
    int passed = 0;
    logic [1:0]   sb[$];
    logic [1:0]   mon_exp;
    logic         req_seen;
    logic [143:0] exp_map;
    logic         hold_ok;

    bomb_controller dut (
        .Frame_Clk     (Frame_Clk),
        .Reset         (Reset),
        .Place_Req     (Place_Req),
        .Place_X       (Place_X),
        .Place_Y       (Place_Y),
        .Wall_Map      (Wall_Map),
        .Tree_Map      (Tree_Map),
        .Bomb_Map      (Bomb_Map),
        .Explosion_Map (Explosion_Map),
        .Tree_Clear    (Tree_Clear),
        .Place_Ack     (Place_Ack),
        .Place_Nack    (Place_Nack)
    );

    always #5 Frame_Clk = ~Frame_Clk;

    function automatic logic [143:0] bit_of(input int i);
        logic [143:0] m;
        m = '0;
        m[8'(i)] = 1'b1;
        return m;
    endfunction

    // Scoreboard: every request sampled out of reset must produce the queued outcome.
    always @(posedge Frame_Clk) req_seen <= Place_Req && !Reset;

    always @(negedge Frame_Clk) begin
        if (req_seen === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL place_sb: request with no expected outcome, ack=%b nack=%b", Place_Ack, Place_Nack);
            end else begin
                mon_exp = sb.pop_front();
                if ({Place_Ack, Place_Nack} !== mon_exp)
                    $display("FAIL place_outcome: ack/nack=%b expected %b", {Place_Ack, Place_Nack}, mon_exp);
                else
                    passed++;
            end
        end else if (Place_Ack !== 1'b0 || Place_Nack !== 1'b0) begin
            checks++;
            $display("FAIL spurious_pulse: ack=%b nack=%b expected 00", Place_Ack, Place_Nack);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Frame_Clk);
    endtask

    // Request held for one cycle from a negedge; returns at the negedge after the sampling edge.
    task automatic drive_place(input int x, input int y, input logic acc);
        sb.push_back({acc, ~acc});
        Place_X   = 10'(x);
        Place_Y   = 10'(y);
        Place_Req = 1'b1;
        @(negedge Frame_Clk);
        Place_Req = 1'b0;
    endtask

    task automatic do_reset();
        Wall_Map  = '0;
        Tree_Map  = '0;
        Place_Req = 1'b0;
        Reset     = 1'b1;
        step(1);
        Reset     = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        Place_Req = 1'b1;
        Place_X   = 10'd20;
        Place_Y   = 10'd20;
        step(2);
        checks++;
        if ({Bomb_Map, Explosion_Map, Tree_Clear} !== '0 || {Place_Ack, Place_Nack} !== 2'b00)
            $display("FAIL reset_outputs: bomb=%h expl=%h tc=%h ack=%b nack=%b expected all 0",
                     Bomb_Map, Explosion_Map, Tree_Clear, Place_Ack, Place_Nack);
        else passed++;
        Place_Req = 1'b0;
        Reset     = 1'b0;
    endtask

    task automatic test_single_blast();
        do_reset();
        drive_place(20, 20, 1'b1);
        checks++;
        if (Bomb_Map !== bit_of(0)) $display("FAIL place_bomb_map: got %h expected %h", Bomb_Map, bit_of(0));
        else passed++;
        step(119);
        checks++;
        if (Bomb_Map !== bit_of(0) || Explosion_Map !== '0)
            $display("FAIL last_fuse_cycle: bomb=%h expl=%h expected bomb bit0 only, no blast", Bomb_Map, Explosion_Map);
        else passed++;
        step(1);
        exp_map = bit_of(0) | bit_of(1) | bit_of(2) | bit_of(12) | bit_of(24);
        checks++;
        if (Bomb_Map !== '0 || Explosion_Map !== exp_map)
            $display("FAIL blast_entry: bomb=%h expl=%h expected bomb 0, expl %h", Bomb_Map, Explosion_Map, exp_map);
        else passed++;
        hold_ok = 1'b1;
        for (int k = 0; k < 29; k++) begin
            step(1);
            if (Explosion_Map !== exp_map) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) $display("FAIL blast_hold: expl=%h expected %h for 30 cycles", Explosion_Map, exp_map);
        else passed++;
        step(1);
        checks++;
        if (Explosion_Map !== '0) $display("FAIL blast_end: expl=%h expected 0", Explosion_Map);
        else passed++;
    endtask

    task automatic test_wall_tree();
        do_reset();
        Wall_Map[1]  = 1'b1;
        Tree_Map[12] = 1'b1;
        drive_place(20, 20, 1'b1);
        step(119);
        checks++;
        if (Tree_Clear !== '0) $display("FAIL tree_clear_early: got %h expected 0", Tree_Clear);
        else passed++;
        step(1);
        checks++;
        if (Explosion_Map !== (bit_of(0) | bit_of(12)) || Tree_Clear !== bit_of(12))
            $display("FAIL wall_tree_blast: expl=%h tc=%h expected expl bits{0,12}, tc bit12", Explosion_Map, Tree_Clear);
        else passed++;
        step(1);
        checks++;
        if (Tree_Clear !== '0 || Explosion_Map !== (bit_of(0) | bit_of(12)))
            $display("FAIL tree_clear_pulse: tc=%h expl=%h expected tc 0, expl bits{0,12}", Tree_Clear, Explosion_Map);
        else passed++;
        step(30);
    endtask

    task automatic test_chain();
        do_reset();
        drive_place(20, 20, 1'b1);
        step(49);
        drive_place(100, 20, 1'b1);
        step(70);
        checks++;
        if (Bomb_Map !== bit_of(2) ||
            Explosion_Map !== (bit_of(0) | bit_of(1) | bit_of(2) | bit_of(12) | bit_of(24)))
            $display("FAIL chain_first_blast: bomb=%h expl=%h", Bomb_Map, Explosion_Map);
        else passed++;
        step(1);
        exp_map = bit_of(0) | bit_of(1) | bit_of(2) | bit_of(3) | bit_of(4) |
                  bit_of(12) | bit_of(14) | bit_of(24) | bit_of(26);
        checks++;
        if (Bomb_Map !== '0 || Explosion_Map !== exp_map)
            $display("FAIL chain_second_blast: bomb=%h expl=%h expected bomb 0, expl %h", Bomb_Map, Explosion_Map, exp_map);
        else passed++;
        step(40);
        checks++;
        if (Explosion_Map !== '0) $display("FAIL chain_drain: expl=%h expected 0", Explosion_Map);
        else passed++;
    endtask

    task automatic test_reject();
        do_reset();
        Wall_Map[5] = 1'b1;
        Tree_Map[7] = 1'b1;
        drive_place(20, 20, 1'b1);
        drive_place(20, 20, 1'b0);     // duplicate cell
        drive_place(500, 20, 1'b0);    // col 12
        drive_place(20, 500, 1'b0);    // row 12
        drive_place(10, 20, 1'b0);     // left of origin
        drive_place(220, 20, 1'b0);    // wall cell 5
        drive_place(300, 20, 1'b0);    // tree cell 7
        drive_place(460, 460, 1'b1);   // corner cell 143
        drive_place(100, 20, 1'b1);
        drive_place(180, 20, 1'b1);
        drive_place(340, 20, 1'b0);    // all slots busy
        checks++;
        exp_map = bit_of(0) | bit_of(2) | bit_of(4) | bit_of(143);
        if (Bomb_Map !== exp_map) $display("FAIL reject_bomb_map: got %h expected %h", Bomb_Map, exp_map);
        else passed++;
    endtask

    task automatic test_reset_mid_fuse();
        do_reset();
        drive_place(20, 20, 1'b1);
        drive_place(100, 20, 1'b1);
        drive_place(180, 20, 1'b1);
        step(10);
        Reset     = 1'b1;
        Place_Req = 1'b1;
        Place_X   = 10'd60;
        Place_Y   = 10'd20;
        step(1);
        Reset     = 1'b0;
        Place_Req = 1'b0;
        checks++;
        if ({Bomb_Map, Explosion_Map, Tree_Clear} !== '0 || {Place_Ack, Place_Nack} !== 2'b00)
            $display("FAIL reset_mid_fuse: bomb=%h expl=%h ack=%b nack=%b expected all 0",
                     Bomb_Map, Explosion_Map, Place_Ack, Place_Nack);
        else passed++;
        drive_place(60, 20, 1'b1);
        checks++;
        if (Bomb_Map !== bit_of(1)) $display("FAIL post_reset_place: got %h expected %h", Bomb_Map, bit_of(1));
        else passed++;
    endtask

    task automatic test_reset_at_detonation();
        do_reset();
        Tree_Map[12] = 1'b1;
        drive_place(20, 20, 1'b1);
        step(119);
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
        checks++;
        if (Tree_Clear !== '0 || Explosion_Map !== '0 || Bomb_Map !== '0)
            $display("FAIL reset_no_tree_clear: tc=%h expl=%h bomb=%h expected all 0", Tree_Clear, Explosion_Map, Bomb_Map);
        else passed++;
    endtask

    initial begin
        Reset     = 1'b1;
        Place_Req = 1'b0;
        Place_X   = '0;
        Place_Y   = '0;
        Wall_Map  = '0;
        Tree_Map  = '0;
        test_reset();
        test_single_blast();
        test_wall_tree();
        test_chain();
        test_reject();
        test_reset_mid_fuse();
        test_reset_at_detonation();
        step(2);
        checks++;
        if (sb.size() != 0) $display("FAIL sb_leftover: %0d outcomes never observed, expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
